// File: rtl/pixel_pair_serializer.sv
// Pixel-pair serializer: buffers even/odd RGB pairs in a FIFO and streams them one pixel per
// cycle with line/frame markers. Define GRAYSCALE_OUT_EN to replace RGB with (R+2G+B)>>2.
module pixel_pair_serializer #(
    parameter int unsigned IMAGE_WIDTH  = 768,
    parameter int unsigned IMAGE_HEIGHT = 512,
    parameter int unsigned FIFO_DEPTH   = 512
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_R_Even,
    input  logic [7:0] data_G_Even,
    input  logic [7:0] data_B_Even,
    input  logic [7:0] data_R_Odd,
    input  logic [7:0] data_G_Odd,
    input  logic [7:0] data_B_Odd,
    input  logic       horizontal_Pulse,
    input  logic       vertical_Pulse,
    output logic [7:0] pix_R,
    output logic [7:0] pix_G,
    output logic [7:0] pix_B,
    output logic       pix_Valid,
    input  logic       pix_Ready,
    output logic       pix_Last_Line,
    output logic       pix_Last_Frame,
    output logic       overflow_Flag,
    output logic       done_Flag
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned COL_W  = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int unsigned ROW_W  = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int unsigned PX_W   = 24;
    localparam int unsigned PAIR_W = 2 * PX_W;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMAGE_HEIGHT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t               state;
    logic                 vp_prev;
    logic                 vp_rise_q;
    logic [PAIR_W-1:0]    mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 out_phase;
    logic [COL_W-1:0]     col;
    logic [ROW_W-1:0]     row;

    logic                 flush_c;
    logic                 xfer_c;
    logic                 full_c;
    logic                 wr_en_c;
    logic                 drop_c;
    logic                 pop_c;
    logic [PTR_W-1:0]     rd_next_c;
    logic [PTR_W-1:0]     wr_addr_c;
    logic [CNT_W-1:0]     count_n_c;
    logic                 load_c;
    logic                 load_odd_c;
    logic [PX_W-1:0]      load_px_c;
    logic [COL_W-1:0]     col_n_c;
    logic [ROW_W-1:0]     row_n_c;
    logic                 frame_end_c;

    // Output channel formatting; luma is applied before the output register so it adds no cycle.
    function automatic logic [PX_W-1:0] fmt_px(input logic [PX_W-1:0] px);
`ifdef GRAYSCALE_OUT_EN
        logic [9:0] sum;
        sum = 10'(px[23:16]) + 10'({px[15:8], 1'b0}) + 10'(px[7:0]);
        return {sum[9:2], sum[9:2], sum[9:2]};
`else
        return px;
`endif
    endfunction

    // Handshake, FIFO bookkeeping, next output pixel and position counters.
    always_comb begin
        flush_c     = vp_rise_q;
        xfer_c      = pix_Valid & pix_Ready;
        full_c      = (count == CNT_W'(FIFO_DEPTH));
        wr_en_c     = horizontal_Pulse & (flush_c | ((state == ST_STREAM) & ~full_c));
        drop_c      = horizontal_Pulse & ~flush_c & (state == ST_STREAM) & full_c;
        pop_c       = xfer_c & out_phase & ~flush_c;
        rd_next_c   = rd_ptr + PTR_W'(1);
        wr_addr_c   = flush_c ? '0 : wr_ptr;
        count_n_c   = flush_c ? CNT_W'(wr_en_c)
                              : count + CNT_W'(wr_en_c) - CNT_W'(pop_c);
        load_c      = 1'b0;
        load_odd_c  = 1'b0;
        load_px_c   = '0;
        col_n_c     = col;
        row_n_c     = row;
        frame_end_c = 1'b0;

        if (!flush_c) begin
            if (!pix_Valid) begin
                if (count != '0) begin
                    load_c    = 1'b1;
                    load_px_c = mem[rd_ptr][PAIR_W-1:PX_W];
                end
            end else if (xfer_c) begin
                if (!out_phase) begin
                    load_c     = 1'b1;
                    load_odd_c = 1'b1;
                    load_px_c  = mem[rd_ptr][PX_W-1:0];
                end else if (count > CNT_W'(1)) begin
                    // Next pair is already queued: continue without a bubble.
                    load_c    = 1'b1;
                    load_px_c = mem[rd_next_c][PAIR_W-1:PX_W];
                end
            end
        end

        if (flush_c) begin
            col_n_c = '0;
            row_n_c = '0;
        end else if (xfer_c) begin
            if (col == LAST_COL) begin
                col_n_c = '0;
                row_n_c = (row == LAST_ROW) ? '0 : row + ROW_W'(1);
            end else begin
                col_n_c = col + COL_W'(1);
            end
            frame_end_c = (state == ST_STREAM) & (col == LAST_COL) & (row == LAST_ROW);
        end
    end

    // Pair storage; contents are don't-care until counted, so no reset.
    always_ff @(posedge clk) begin
        if (!reset && wr_en_c) begin
            mem[wr_addr_c] <= {data_R_Even, data_G_Even, data_B_Even,
                               data_R_Odd,  data_G_Odd,  data_B_Odd};
        end
    end

    // Control FSM, FIFO pointers, output register and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            vp_prev        <= 1'b0;
            vp_rise_q      <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            out_phase      <= 1'b0;
            col            <= '0;
            row            <= '0;
            pix_R          <= '0;
            pix_G          <= '0;
            pix_B          <= '0;
            pix_Valid      <= 1'b0;
            pix_Last_Line  <= 1'b0;
            pix_Last_Frame <= 1'b0;
            overflow_Flag  <= 1'b0;
            done_Flag      <= 1'b0;
        end else begin
            vp_prev   <= vertical_Pulse;
            vp_rise_q <= vertical_Pulse & ~vp_prev;

            case (state)
                ST_IDLE: begin
                    if (flush_c) begin
                        state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (frame_end_c) begin
                        state     <= ST_DONE;
                        done_Flag <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (flush_c) begin
                        state     <= ST_STREAM;
                        done_Flag <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    done_Flag <= 1'b0;
                end
            endcase

            if (flush_c) begin
                rd_ptr <= '0;
                wr_ptr <= PTR_W'(wr_en_c);
            end else begin
                if (wr_en_c) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop_c) begin
                    rd_ptr <= rd_next_c;
                end
            end
            count <= count_n_c;

            if (drop_c) begin
                overflow_Flag <= 1'b1;
            end

            if (flush_c) begin
                pix_Valid <= 1'b0;
                out_phase <= 1'b0;
                pix_R     <= '0;
                pix_G     <= '0;
                pix_B     <= '0;
            end else if (load_c) begin
                pix_Valid             <= 1'b1;
                out_phase             <= load_odd_c;
                {pix_R, pix_G, pix_B} <= fmt_px(load_px_c);
            end else if (xfer_c) begin
                pix_Valid <= 1'b0;
                out_phase <= 1'b0;
            end

            // Counters track the pixel being presented, so the markers follow the next position.
            col            <= col_n_c;
            row            <= row_n_c;
            pix_Last_Line  <= (col_n_c == LAST_COL);
            pix_Last_Frame <= (col_n_c == LAST_COL) && (row_n_c == LAST_ROW);
        end
    end

endmodule

// File: tb/tb_pixel_pair_serializer.sv
// Directed bench for pixel_pair_serializer (4x2 image, 2-entry FIFO) with an expected-pixel queue.
module tb_pixel_pair_serializer;

    localparam int unsigned W = 4;
    localparam int unsigned H = 2;
    localparam int unsigned D = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_R_Even, data_G_Even, data_B_Even;
    logic [7:0] data_R_Odd, data_G_Odd, data_B_Odd;
    logic       horizontal_Pulse;
    logic       vertical_Pulse;
    logic [7:0] pix_R, pix_G, pix_B;
    logic       pix_Valid;
    logic       pix_Ready;
    logic       pix_Last_Line;
    logic       pix_Last_Frame;
    logic       overflow_Flag;
    logic       done_Flag;

    typedef struct packed {
        logic [23:0] px;
        logic        ll;
        logic        lf;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   xfers    = 0;
    int   pos      = 0;

    pixel_pair_serializer #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .FIFO_DEPTH  (D)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .data_R_Even     (data_R_Even),
        .data_G_Even     (data_G_Even),
        .data_B_Even     (data_B_Even),
        .data_R_Odd      (data_R_Odd),
        .data_G_Odd      (data_G_Odd),
        .data_B_Odd      (data_B_Odd),
        .horizontal_Pulse(horizontal_Pulse),
        .vertical_Pulse  (vertical_Pulse),
        .pix_R           (pix_R),
        .pix_G           (pix_G),
        .pix_B           (pix_B),
        .pix_Valid       (pix_Valid),
        .pix_Ready       (pix_Ready),
        .pix_Last_Line   (pix_Last_Line),
        .pix_Last_Frame  (pix_Last_Frame),
        .overflow_Flag   (overflow_Flag),
        .done_Flag       (done_Flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [23:0] model_px(input logic [7:0] r, input logic [7:0] g,
                                             input logic [7:0] b);
`ifdef GRAYSCALE_OUT_EN
        int unsigned s;
        s = int'(r) + 2 * int'(g) + int'(b);
        s = s / 4;
        return {8'(s), 8'(s), 8'(s)};
`else
        return {r, g, b};
`endif
    endfunction

    task automatic push_px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        exp_t e;
        int   c;
        int   rw;
        c    = pos % W;
        rw   = (pos / W) % H;
        e.px = model_px(r, g, b);
        e.ll = (c == W - 1);
        e.lf = (c == W - 1) && (rw == H - 1);
        sb.push_back(e);
        pos++;
    endtask

    // One clock: score any transfer happening at the coming edge, then settle past it.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (pix_Valid && pix_Ready) begin
            xfers++;
            if (sb.size() == 0) begin
                chk("unexpected_xfer", 32'(pix_Valid), 0);
            end else begin
                e = sb.pop_front();
                chk("pix_rgb", {pix_R, pix_G, pix_B}, e.px);
                chk("last_line", 32'(pix_Last_Line), 32'(e.ll));
                chk("last_frame", 32'(pix_Last_Frame), 32'(e.lf));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [7:0] re, input logic [7:0] ge, input logic [7:0] be,
                         input logic [7:0] ro, input logic [7:0] go, input logic [7:0] bo,
                         input bit accept);
        data_R_Even = re; data_G_Even = ge; data_B_Even = be;
        data_R_Odd  = ro; data_G_Odd  = go; data_B_Odd  = bo;
        horizontal_Pulse = 1'b1;
        if (accept) begin
            push_px(re, ge, be);
            push_px(ro, go, bo);
        end
        step();
        horizontal_Pulse = 1'b0;
    endtask

    task automatic vp_edge();
        vertical_Pulse = 1'b1;
        step();
        step();
        vertical_Pulse = 1'b0;
        sb.delete();
        pos = 0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        int base;
        int n;
        reset = 1'b1;
        horizontal_Pulse = 1'b0;
        vertical_Pulse   = 1'b0;
        pix_Ready        = 1'b1;
        data_R_Even = '0; data_G_Even = '0; data_B_Even = '0;
        data_R_Odd  = '0; data_G_Odd  = '0; data_B_Odd  = '0;
        step();
        step();
        chk("rst_valid", 32'(pix_Valid), 0);
        chk("rst_rgb", {pix_R, pix_G, pix_B}, 0);
        chk("rst_last_line", 32'(pix_Last_Line), 0);
        chk("rst_last_frame", 32'(pix_Last_Frame), 0);
        chk("rst_overflow", 32'(overflow_Flag), 0);
        chk("rst_done", 32'(done_Flag), 0);
        reset = 1'b0;

        // Pairs before any frame marker are ignored silently.
        offer(1, 2, 3, 4, 5, 6, 0);
        step();
        offer(7, 8, 9, 10, 11, 12, 0);
        repeat (4) step();
        chk("idle_valid", 32'(pix_Valid), 0);
        chk("idle_overflow", 32'(overflow_Flag), 0);

        // Single-pair latency.
        vp_edge();
        offer(10, 20, 30, 40, 50, 60, 1);
        chk("lat_t0_valid", 32'(pix_Valid), 0);
        step();
        chk("lat_t1_valid", 32'(pix_Valid), 1);
        chk("lat_t1_rgb", {pix_R, pix_G, pix_B}, model_px(10, 20, 30));
        step();
        chk("lat_t2_valid", 32'(pix_Valid), 1);
        chk("lat_t2_rgb", {pix_R, pix_G, pix_B}, model_px(40, 50, 60));
        step();
        chk("lat_t3_valid", 32'(pix_Valid), 0);

        // Full 4x2 frame, first pair coinciding with the flushing edge.
        vertical_Pulse = 1'b1;
        step();
        sb.delete();
        pos = 0;
        offer(255, 255, 255, 100, 0, 0, 1);
        vertical_Pulse = 1'b0;
        step();
        offer(1, 2, 3, 4, 5, 6, 1);
        step();
        offer(200, 100, 50, 7, 8, 9, 1);
        step();
        offer(0, 0, 0, 17, 34, 51, 1);
        chk("frame_done_early", 32'(done_Flag), 0);
        drain(20);
        chk("frame_done", 32'(done_Flag), 1);
        chk("frame_end_valid", 32'(pix_Valid), 0);

        // Pairs in DONE are discarded without overflow.
        offer(7, 7, 7, 7, 7, 7, 0);
        repeat (3) step();
        chk("done_discard_valid", 32'(pix_Valid), 0);
        chk("done_discard_ovf", 32'(overflow_Flag), 0);
        chk("done_hold", 32'(done_Flag), 1);

        // Frame marker mid-line restarts counting at column 0, row 0.
        vp_edge();
        chk("restart_done_clr", 32'(done_Flag), 0);
        base = xfers;
        offer(11, 12, 13, 14, 15, 16, 1);
        step();
        offer(21, 22, 23, 24, 25, 26, 1);
        step();
        n = 0;
        while (xfers < base + 3 && n < 20) begin
            step();
            n++;
        end
        chk("midline_xfers", xfers, base + 3);
        pix_Ready = 1'b0;
        vp_edge();
        chk("flush_valid", 32'(pix_Valid), 0);
        chk("flush_done", 32'(done_Flag), 0);
        pix_Ready = 1'b1;
        offer(31, 32, 33, 34, 35, 36, 1);
        step();
        offer(41, 42, 43, 44, 45, 46, 1);
        drain(20);
        chk("flush_end_valid", 32'(pix_Valid), 0);

        // Stall with a 2-deep FIFO: third back-to-back pair overflows.
        pix_Ready = 1'b0;
        vp_edge();
        offer(51, 52, 53, 54, 55, 56, 1);
        offer(61, 62, 63, 64, 65, 66, 1);
        offer(71, 72, 73, 74, 75, 76, 0);
        chk("ovf_set", 32'(overflow_Flag), 1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_hold", {pix_R, pix_G, pix_B, pix_Valid, pix_Last_Line, pix_Last_Frame},
                {model_px(51, 52, 53), 3'b100});
            chk("ovf_sticky", 32'(overflow_Flag), 1);
        end
        pix_Ready = 1'b1;
        drain(20);
        chk("ovf_after_drain", 32'(overflow_Flag), 1);
        chk("stall_end_valid", 32'(pix_Valid), 0);

        // Reset in the middle of a stalled handshake.
        pix_Ready = 1'b0;
        vp_edge();
        offer(81, 82, 83, 84, 85, 86, 1);
        step();
        chk("pre_rst_valid", 32'(pix_Valid), 1);
        reset = 1'b1;
        step();
        chk("mid_rst_valid", 32'(pix_Valid), 0);
        chk("mid_rst_rgb", {pix_R, pix_G, pix_B}, 0);
        chk("mid_rst_ovf", 32'(overflow_Flag), 0);
        chk("mid_rst_done", 32'(done_Flag), 0);
        reset = 1'b0;
        sb.delete();
        pos = 0;
        pix_Ready = 1'b1;
        offer(91, 92, 93, 94, 95, 96, 0);
        repeat (4) step();
        chk("post_rst_idle", 32'(pix_Valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_pair_serializer.md
PIXEL_PAIR_SERIALIZER -- requirements
Module: pixel_pair_serializer

Interface
REQ-001 SHALL have parameter IMAGE_WIDTH, default 768: pixels per line; even, at least 2.
REQ-002 SHALL have parameter IMAGE_HEIGHT, default 512: lines per frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 512: pixel-pair FIFO entries; a power of two, at least 2.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 data_R_Even, data_G_Even, data_B_Even  input  8 each  even (left) pixel of the pair.
REQ-007 data_R_Odd, data_G_Odd, data_B_Odd  input  8 each  odd (right) pixel of the pair.
REQ-008 horizontal_Pulse  input  1  qualifies the input pair; one pair is offered per high cycle.
REQ-009 vertical_Pulse  input  1  frame marker; only its rising edge is significant.
REQ-010 pix_R, pix_G, pix_B  output  8 each  serialized pixel.
REQ-011 pix_Valid  output  1  output pixel valid.
REQ-012 pix_Ready  input  1  downstream accept.
REQ-013 pix_Last_Line  output  1  current output pixel is the last in its line.
REQ-014 pix_Last_Frame  output  1  current output pixel is the last in its frame.
REQ-015 overflow_Flag  output  1  sticky; a pair was dropped.
REQ-016 done_Flag  output  1  frame fully transferred.

Function
REQ-017 SHALL run a three-state FSM:
- IDLE to STREAM on a vertical_Pulse rising edge.
- STREAM to DONE when the output pixel at column IMAGE_WIDTH-1, row IMAGE_HEIGHT-1 transfers.
- DONE to STREAM on a vertical_Pulse rising edge.
REQ-018 SHALL detect the vertical_Pulse rising edge with a registered previous value; the state change takes effect on the edge after the one where the 0-to-1 transition is sampled.
REQ-019 SHALL write the pair to the FIFO when horizontal_Pulse=1 in STREAM and the FIFO is not full.
REQ-020 SHALL discard pairs offered in IDLE or DONE without setting overflow_Flag.
REQ-021 SHALL determine fullness from occupancy before any same-cycle pop; a write when full is dropped and sets overflow_Flag.
REQ-022 SHALL present the even pixel of each pair first, then the odd pixel; the FIFO entry pops when the odd pixel transfers.
REQ-023 A transfer SHALL occur when pix_Valid=1 and pix_Ready=1.
REQ-024 While pix_Valid=1 and pix_Ready=0, all pix_* outputs SHALL hold stable.
REQ-025 Latency: a pair sampled at edge t into an empty FIFO SHALL give pix_Valid=1 with the even pixel after edge t+1, and the odd pixel after edge t+2 if pix_Ready=1.
REQ-026 With continuous pix_Ready=1 and a non-empty FIFO, SHALL output one pixel per cycle with no bubble between pairs.
REQ-027 SHALL keep column and row counters of transferred pixels:
- Column wraps at IMAGE_WIDTH-1 to 0 and increments row.
- Row wraps at IMAGE_HEIGHT-1 to 0.
REQ-028 pix_Last_Line SHALL equal (column==IMAGE_WIDTH-1); pix_Last_Frame SHALL additionally require row==IMAGE_HEIGHT-1.
REQ-029 A vertical_Pulse rising edge SHALL flush the FIFO and the output register, zero the counters, and clear done_Flag.
REQ-030 If horizontal_Pulse=1 coincides with the flushing edge, the pair SHALL be written after the flush as column 0, row 0.
REQ-031 done_Flag SHALL be 1 exactly while in DONE.
REQ-032 Sustained input SHALL NOT exceed one pixel per cycle averaged over a line; excess is handled only by drop and overflow_Flag.

Reset
REQ-033 On reset=1, at the next edge SHALL:
- enter IDLE and empty the FIFO;
- set counters to 0;
- drive pix_R/G/B=0, pix_Valid=0, pix_Last_Line=0, pix_Last_Frame=0, overflow_Flag=0, done_Flag=0;
- clear the vertical_Pulse edge register.
REQ-034 Reset SHALL take precedence over every other event, including mid-frame and mid-handshake.

Configuration
REQ-035 With macro GRAYSCALE_OUT_EN defined, pix_R=pix_G=pix_B=(R+2*G+B)>>2, computed at 10-bit width and truncated to 8 bits, with no added latency.
REQ-036 Without GRAYSCALE_OUT_EN, the RGB channels SHALL pass through unchanged.

Verification
REQ-037 Reset, vertical_Pulse edge, one pair (even 10/20/30, odd 40/50/60), pix_Ready=1 -> pixel 10/20/30 after t+1, then 40/50/60 after t+2, then pix_Valid=0.
REQ-038 IMAGE_WIDTH=4, IMAGE_HEIGHT=2, full frame -> pix_Last_Line on pixels 3 and 7, pix_Last_Frame on pixel 7, done_Flag=1 the next cycle.
REQ-039 pix_Ready=0 for 10 cycles with FIFO_DEPTH=2 and 3 pairs offered -> third pair dropped, overflow_Flag=1 and stays 1; outputs stable throughout.
REQ-040 Pairs offered before the first vertical_Pulse edge -> no pix_Valid, overflow_Flag=0.
REQ-041 vertical_Pulse edge mid-line -> FIFO flushed, next pixel reports column 0, row 0, done_Flag=0.
REQ-042 With GRAYSCALE_OUT_EN and input 255/255/255 -> output 255/255/255; input 100/0/0 -> 25/25/25.
